// File: rtl/eviction_event_recorder.sv
// Eviction event recorder: logs prioritised cache eviction events as (class code, trace) pairs
// into a stall-on-full or circular buffer, with per-class counters and an oldest-first read port.
module eviction_event_recorder #(
    parameter int unsigned COUNTER_BW = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned CODE_BW    = 2
) (
    input  logic                       clock_i,
    input  logic                       resetn_i,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic                       wrap_mode_i,
    input  logic [N_SRC-1:0]           event_i,
    input  logic [COUNTER_BW-1:0]      reference_counter_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    input  logic [$clog2(N_SRC)-1:0]   class_sel_i,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       wrapped_o,
    output logic [31:0]                dropped_o,
    output logic [COUNTER_BW-1:0]      rd_trace_o,
    output logic [CODE_BW-1:0]         rd_code_o,
    output logic [31:0]                class_count_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned SCW = 32;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  stall_q, stall_d;
    logic                  wrapped_q, wrapped_d;
    logic [SCW-1:0]        dropped_q, dropped_d;
    logic [SCW-1:0]        class_cnt_q [N_SRC];
    logic [SCW-1:0]        class_cnt_d [N_SRC];
    logic [COUNTER_BW-1:0] rd_trace_q;
    logic [CODE_BW-1:0]    rd_code_q;

    logic [COUNTER_BW-1:0] trace_mem [DEPTH];
    logic [CODE_BW-1:0]    code_mem  [DEPTH];

    logic                  hit_c, accept_c, drop_c, full_c;
    logic [CODE_BW-1:0]    code_c;
    logic [COUNTER_BW-1:0] trace_c;
    logic [AW-1:0]         rd_phys_c;

    // Lowest set event bit wins; trace word is the 0-based reference index.
    always_comb begin
        code_c = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (event_i[i]) code_c = CODE_BW'(i);
        end
        hit_c     = |event_i;
        trace_c   = reference_counter_i - COUNTER_BW'(1);
        accept_c  = en_i & hit_c & ~stall_q & ~clear_i;
        drop_c    = en_i & hit_c & stall_q & ~clear_i;
        full_c    = (count_q == FULL);
        rd_phys_c = (full_c && wrapped_q) ? wr_ptr_q + rd_addr_i : rd_addr_i;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        stall_d   = stall_q;
        wrapped_d = wrapped_q;
        dropped_d = dropped_q;
        for (int unsigned i = 0; i < N_SRC; i++) class_cnt_d[i] = class_cnt_q[i];

        if (clear_i) begin
            wr_ptr_d  = '0;
            count_d   = '0;
            stall_d   = 1'b0;
            wrapped_d = 1'b0;
            dropped_d = '0;
            for (int unsigned i = 0; i < N_SRC; i++) class_cnt_d[i] = '0;
        end else begin
            if (accept_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (full_c) wrapped_d = 1'b1;
                else        count_d   = count_q + CW'(1);
                for (int unsigned i = 0; i < N_SRC; i++) begin
                    if (code_c == CODE_BW'(i) && class_cnt_q[i] != '1)
                        class_cnt_d[i] = class_cnt_q[i] + SCW'(1);
                end
            end
            if (drop_c && dropped_q != '1) dropped_d = dropped_q + SCW'(1);
            // Stall follows the next count so it rises on the edge that writes the last slot.
            stall_d = ~wrap_mode_i & (count_d == FULL);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            wr_ptr_q  <= '0;
            count_q   <= '0;
            stall_q   <= 1'b0;
            wrapped_q <= 1'b0;
            dropped_q <= '0;
            for (int unsigned i = 0; i < N_SRC; i++) class_cnt_q[i] <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            stall_q   <= stall_d;
            wrapped_q <= wrapped_d;
            dropped_q <= dropped_d;
            for (int unsigned i = 0; i < N_SRC; i++) class_cnt_q[i] <= class_cnt_d[i];
        end
    end

    // Buffer storage: not reset; read returns pre-write data on a same-address collision.
    always_ff @(posedge clock_i) begin
        if (accept_c) begin
            trace_mem[wr_ptr_q] <= trace_c;
            code_mem[wr_ptr_q]  <= code_c;
        end
        rd_trace_q <= trace_mem[rd_phys_c];
        rd_code_q  <= code_mem[rd_phys_c];
    end

    always_comb begin
        class_count_o = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (32'(class_sel_i) == i) class_count_o = class_cnt_q[i];
        end
    end

    assign stall_o    = stall_q;
    assign count_o    = count_q;
    assign wrapped_o  = wrapped_q;
    assign dropped_o  = dropped_q;
    assign rd_trace_o = rd_trace_q;
    assign rd_code_o  = rd_code_q;

endmodule

// File: tb/tb_eviction_event_recorder.sv
// Directed bench for eviction_event_recorder at DEPTH=8, N_SRC=4, COUNTER_BW=16.
module tb_eviction_event_recorder;

    logic        clk = 1'b0;
    logic        resetn, en, clear, wrap;
    logic [3:0]  event_v;
    logic [15:0] ref_v;
    logic [2:0]  rd_addr;
    logic [1:0]  class_sel;
    logic        stall, wrapped;
    logic [3:0]  count;
    logic [31:0] dropped, class_count;
    logic [15:0] rd_trace;
    logic [1:0]  rd_code;

    int errors = 0;
    int checks = 0;

    eviction_event_recorder #(
        .COUNTER_BW(16), .DEPTH(8), .N_SRC(4), .CODE_BW(2)
    ) dut (
        .clock_i(clk), .resetn_i(resetn), .en_i(en), .clear_i(clear),
        .wrap_mode_i(wrap), .event_i(event_v), .reference_counter_i(ref_v),
        .rd_addr_i(rd_addr), .class_sel_i(class_sel), .stall_o(stall),
        .count_o(count), .wrapped_o(wrapped), .dropped_o(dropped),
        .rd_trace_o(rd_trace), .rd_code_o(rd_code), .class_count_o(class_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fire(input logic [3:0] ev, input logic [15:0] r);
        event_v = ev;
        ref_v   = r;
        step();
        event_v = 4'b0000;
    endtask

    task automatic chk_class(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        class_sel = sel;
        #1;
        chk(tag, class_count, exp);
    endtask

    task automatic chk_read(input string tag, input logic [2:0] a,
                            input logic [15:0] exp_trace, input logic [1:0] exp_code);
        rd_addr = a;
        step();
        chk({tag, "_trace"}, 32'(rd_trace), 32'(exp_trace));
        chk({tag, "_code"},  32'(rd_code),  32'(exp_code));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; clear = 1'b0; wrap = 1'b0;
        event_v = '0; ref_v = '0; rd_addr = '0; class_sel = '0;
        step(); step();
        resetn = 1'b1;
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        chk("rst_dropped", dropped, 32'd0);
        for (int i = 0; i < 4; i++) chk_class("rst_class", 2'(i), 32'd0);

        // Two flags set: bit 1 outranks bit 2
        en = 1'b1;
        fire(4'b0110, 16'd5);
        chk("first_count", 32'(count), 32'd1);
        chk_class("first_class1", 2'd1, 32'd1);
        chk_class("first_class2", 2'd2, 32'd0);
        chk_read("first_rd", 3'd0, 16'd4, 2'd1);

        // Stall mode: fill, then three dropped events
        do_clear();
        for (int r = 1; r <= 8; r++) begin
            chk("fill_stall_low", 32'(stall), 32'd0);
            fire(4'b1000, 16'(r));
        end
        chk("fill_stall", 32'(stall), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        for (int r = 9; r <= 11; r++) fire(4'b1000, 16'(r));
        chk("drop_count", 32'(count), 32'd8);
        chk("drop_dropped", dropped, 32'd3);
        chk("drop_wrapped", 32'(wrapped), 32'd0);
        chk_class("drop_class3", 2'd3, 32'd8);
        for (int a = 0; a < 8; a++) chk_read("stall_rd", 3'(a), 16'(a), 2'd3);

        // Clear beats a simultaneous event while stalled
        clear = 1'b1;
        fire(4'b0001, 16'd7);
        clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_stall", 32'(stall), 32'd0);
        chk("clr_dropped", dropped, 32'd0);
        chk("clr_wrapped", 32'(wrapped), 32'd0);
        for (int i = 0; i < 4; i++) chk_class("clr_class", 2'(i), 32'd0);

        // Wrap mode: 11 events into 8 slots
        wrap = 1'b1;
        for (int r = 1; r <= 11; r++) fire(4'b1000, 16'(r));
        chk("wrap_count", 32'(count), 32'd8);
        chk("wrap_wrapped", 32'(wrapped), 32'd1);
        chk("wrap_stall", 32'(stall), 32'd0);
        chk_class("wrap_class3", 2'd3, 32'd11);
        chk_read("wrap_rd0", 3'd0, 16'd3, 2'd3);
        chk_read("wrap_rd7", 3'd7, 16'd10, 2'd3);
        chk_read("wrap_rd5", 3'd5, 16'd8, 2'd3);

        // Reference 0 stores all-ones; it becomes the newest entry
        fire(4'b0001, 16'd0);
        chk_read("ref0_rd7", 3'd7, 16'hFFFF, 2'd0);
        chk_read("ref0_rd0", 3'd0, 16'd4, 2'd3);
        chk_class("ref0_class0", 2'd0, 32'd1);

        // Disabled recording ignores events
        en = 1'b0;
        fire(4'b0001, 16'd3);
        en = 1'b1;
        chk_class("dis_class0", 2'd0, 32'd1);

        // Stalled, then switch to wrap mode and resume
        wrap = 1'b0;
        do_clear();
        for (int r = 1; r <= 8; r++) fire(4'b0100, 16'(r));
        chk("sw_stall_hi", 32'(stall), 32'd1);
        wrap = 1'b1;
        step();
        chk("sw_stall_lo", 32'(stall), 32'd0);
        chk("sw_count", 32'(count), 32'd8);
        chk("sw_wrapped_lo", 32'(wrapped), 32'd0);
        fire(4'b0010, 16'd20);
        chk("sw_wrapped_hi", 32'(wrapped), 32'd1);
        chk("sw_stall", 32'(stall), 32'd0);
        chk("sw_count2", 32'(count), 32'd8);
        chk_read("sw_rd7", 3'd7, 16'd19, 2'd1);
        chk_read("sw_rd0", 3'd0, 16'd1, 2'd2);
        chk_class("sw_class1", 2'd1, 32'd1);
        chk_class("sw_class2", 2'd2, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
